// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and helpers for the data memory controller (package dmem_pkg).
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Bit positions in the error-cause vector; any set bit fails the access.
    localparam int ERR_W        = 3;
    localparam int ERR_BOTH     = 0;
    localparam int ERR_MISALIGN = 1;
    localparam int ERR_RANGE    = 2;

    function automatic int ofs_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-side request/response bus of the data memory controller.
interface data_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  mem_rd;
    logic                  mem_wd;
    logic [ADDR_W-1:0]     mem_dir;
    logic [DATA_W-1:0]     mem_dato;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_output;
    logic                  mem_ready;
    logic                  mem_err;

    modport master (
        output mem_rd, mem_wd, mem_dir, mem_dato, mem_be,
        input  mem_output, mem_ready, mem_err
    );

    modport slave (
        input  mem_rd, mem_wd, mem_dir, mem_dato, mem_be,
        output mem_output, mem_ready, mem_err
    );
endinterface

// File: rtl/data_mem_ctrl_array.sv
// Byte-lane storage (module dmem_array): one port, per-lane write enable, registered read.
module dmem_array #(
    parameter int NUM_LANES = 4,
    parameter int DEPTH     = 256,
    parameter int IDX_W     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      re,
    input  logic [NUM_LANES-1:0]      we,
    input  logic [IDX_W-1:0]          idx,
    input  logic [NUM_LANES-1:0][7:0] wdata,
    output logic [NUM_LANES-1:0][7:0] rdata
);
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_byte;

        // Storage itself is never cleared; only the read register resets.
        always_ff @(posedge clk) begin
            if (we[l]) mem[idx] <= wdata[l];
        end

        always_ff @(posedge clk) begin
            if (reset)   rd_byte <= '0;
            else if (re) rd_byte <= mem[idx];
        end

        assign rdata[l] = rd_byte;
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// Clocked data memory controller with wait states and error reporting.
// Optional DMEM_CNT_EN adds saturating rd_count/wr_count of successful accesses.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
`ifdef DMEM_CNT_EN
    ,
    output logic [31:0]    rd_count,
    output logic [31:0]    wr_count
`endif
);
    localparam int NUM_LANES = DATA_W / 8;
    localparam int OFS       = ofs_bits(DATA_W);
    localparam int IW        = ADDR_W - OFS;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT  = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [IW-1:0]    DEPTH_IDX = IW'(DEPTH);

    state_t state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic                      op_rd, op_wr, op_err;
    logic [IDX_W-1:0]          op_idx;
    logic [DATA_W-1:0]         op_data;
    logic [NUM_LANES-1:0]      op_be;
    logic [ERR_W-1:0]          cause;
    logic [IW-1:0]             word;
    logic                      req, accept, access, good, re;
    logic [NUM_LANES-1:0]      we;
    logic [NUM_LANES-1:0][7:0] rdata;
    logic                      ready_q, err_q;

    assign word = bus.mem_dir[ADDR_W-1:OFS];
    assign req  = bus.mem_rd | bus.mem_wd;

    always_comb begin
        cause               = '0;
        cause[ERR_BOTH]     = bus.mem_rd & bus.mem_wd;
        cause[ERR_MISALIGN] = |bus.mem_dir[OFS-1:0];
        cause[ERR_RANGE]    = word >= DEPTH_IDX;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // The access commits on the edge leaving RESP, so mem_ready shows up while
    // the FSM is already back in IDLE and a held request is re-accepted.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: if (req) begin
                accept    = 1'b1;
                state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
            WAIT: if (cnt == '0) state_nxt = RESP;
            RESP: begin
                access    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            op_rd   <= 1'b0;
            op_wr   <= 1'b0;
            op_err  <= 1'b0;
            op_idx  <= '0;
            op_data <= '0;
            op_be   <= '0;
        end else if (accept) begin
            cnt     <= CNT_INIT;
            op_rd   <= bus.mem_rd;
            op_wr   <= bus.mem_wd;
            op_err  <= |cause;
            op_idx  <= word[IDX_W-1:0];
            op_data <= bus.mem_dato;
            op_be   <= bus.mem_be;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign good = access & ~op_err & ~reset;
    assign re   = good & op_rd;
    assign we   = {NUM_LANES{good & op_wr}} & op_be;

    dmem_array #(
        .NUM_LANES (NUM_LANES),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .re    (re),
        .we    (we),
        .idx   (op_idx),
        .wdata (op_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= access;
            err_q   <= access & op_err;
        end
    end

    assign bus.mem_output = rdata;
    assign bus.mem_ready  = ready_q;
    assign bus.mem_err    = err_q;

`ifdef DMEM_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (re && rd_count != '1)            rd_count <= rd_count + 1'b1;
            if (good && op_wr && wr_count != '1) wr_count <= wr_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed table, abort sequence, latency sweep, random vs model.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
    data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus3 ();

`ifdef DMEM_CNT_EN
    logic [31:0] rd_count, wr_count, rc0, wc0, rc3, wc3;
`endif

    data_mem_ctrl #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
`ifdef DMEM_CNT_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );
    data_mem_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
`ifdef DMEM_CNT_EN
        , .rd_count(rc0), .wr_count(wc0)
`endif
    );
    data_mem_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
`ifdef DMEM_CNT_EN
        , .rd_count(rc3), .wr_count(wc3)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: word array plus the last successfully read value.
    logic [31:0] ref_mem [256];
    logic [31:0] ref_out = '0;
    int exp_rd_cnt = 0;
    int exp_wr_cnt = 0;

    task automatic model_op(input logic rd, input logic wd, input logic [31:0] dir,
                            input logic [31:0] dato, input logic [3:0] be,
                            output logic [31:0] eout, output logic eerr);
        int idx;
        idx  = int'(dir >> 2);
        eerr = (rd && wd) || (dir % 4 != 0) || ((dir >> 2) >= 256);
        if (!eerr && wd) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = dato[8*b +: 8];
            exp_wr_cnt++;
        end
        if (!eerr && rd) begin
            ref_out = ref_mem[idx];
            exp_rd_cnt++;
        end
        eout = ref_out;
    endtask

    task automatic do_op(input logic rd, input logic wd, input logic [31:0] dir,
                         input logic [31:0] dato, input logic [3:0] be,
                         output logic [31:0] out, output logic err,
                         output int lat, output longint t_acc);
        @(negedge clk);
        bus.mem_rd = rd; bus.mem_wd = wd; bus.mem_dir = dir;
        bus.mem_dato = dato; bus.mem_be = be;
        @(posedge clk);
        t_acc = $time;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.mem_ready && lat < 20);
        bus.mem_rd = 1'b0; bus.mem_wd = 1'b0;
        out = bus.mem_output;
        err = bus.mem_err;
    endtask

    typedef struct {
        logic        rd, wd;
        logic [31:0] dir, dato;
        logic [3:0]  be;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t tv [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] out, eout, dir;
        logic        err, eerr, rd, wd, saw;
        int          lat;
        longint      t_acc, t_prev;

        tv[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tv[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tv[2] = '{1'b0, 1'b1, 32'h10,  32'h11223344, 4'h5, 32'hDEADBEEF, 1'b0};
        tv[3] = '{1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        tv[4] = '{1'b1, 1'b0, 32'h12,  32'h0,        4'h0, 32'hDE22BE44, 1'b1};
        tv[5] = '{1'b1, 1'b0, 32'h400, 32'h0,        4'h0, 32'hDE22BE44, 1'b1};
        tv[6] = '{1'b1, 1'b1, 32'h10,  32'h0,        4'hF, 32'hDE22BE44, 1'b1};
        tv[7] = '{1'b0, 1'b1, 32'h10,  32'hAAAAAAAA, 4'h0, 32'hDE22BE44, 1'b0};
        tv[8] = '{1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};

        reset = 1'b1;
        bus.mem_rd = 0;  bus.mem_wd = 0;  bus.mem_dir = 0;  bus.mem_dato = 0;  bus.mem_be = 0;
        bus0.mem_rd = 0; bus0.mem_wd = 0; bus0.mem_dir = 0; bus0.mem_dato = 0; bus0.mem_be = 0;
        bus3.mem_rd = 0; bus3.mem_wd = 0; bus3.mem_dir = 0; bus3.mem_dato = 0; bus3.mem_be = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset mem_output", bus.mem_output, 32'h0);
        check("reset mem_ready", {31'b0, bus.mem_ready}, 32'h0);
        check("reset mem_err", {31'b0, bus.mem_err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table, issued back to back.
        t_prev = 0;
        for (int i = 0; i < 9; i++) begin
            model_op(tv[i].rd, tv[i].wd, tv[i].dir, tv[i].dato, tv[i].be, eout, eerr);
            do_op(tv[i].rd, tv[i].wd, tv[i].dir, tv[i].dato, tv[i].be, out, err, lat, t_acc);
            check($sformatf("vec%0d out", i), out, tv[i].exp_out);
            check($sformatf("vec%0d err", i), {31'b0, err}, {31'b0, tv[i].exp_err});
            check($sformatf("vec%0d latency", i), lat, 2);
            if (i > 0) check($sformatf("vec%0d accept period", i), 32'(t_acc - t_prev), 30);
            t_prev = t_acc;
        end
        @(posedge clk); #1;
        check("ready single pulse", {31'b0, bus.mem_ready}, 32'h0);

        // Reset during WAIT aborts a write.
        model_op(1'b0, 1'b1, 32'h20, 32'h0, 4'hF, eout, eerr);
        do_op(1'b0, 1'b1, 32'h20, 32'h0, 4'hF, out, err, lat, t_acc);
        check("clear 0x20 err", {31'b0, err}, 32'h0);
        @(negedge clk);
        bus.mem_wd = 1'b1; bus.mem_dir = 32'h20; bus.mem_dato = 32'hCAFEF00D; bus.mem_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.mem_wd = 1'b0;
        saw = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.mem_ready) saw = 1'b1;
        end
        check("abort no mem_ready", {31'b0, saw}, 32'h0);
        check("abort mem_output reset", bus.mem_output, 32'h0);
        ref_out = '0; exp_rd_cnt = 0; exp_wr_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        model_op(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, eout, eerr);
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, out, err, lat, t_acc);
        check("post-abort read 0x10", out, 32'hDE22BE44);
        model_op(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, eout, eerr);
        do_op(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, out, err, lat, t_acc);
        check("post-abort read 0x20", out, 32'h0);
        check("post-abort err", {31'b0, err}, 32'h0);

        // Latency sweep: request held high, WAIT_CYCLES 0 and 3 side by side.
        @(negedge clk);
        bus0.mem_rd = 1'b1; bus3.mem_rd = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            check($sformatf("W0 ready c%0d", c), {31'b0, bus0.mem_ready}, {31'b0, c % 2 == 1});
            check($sformatf("W3 ready c%0d", c), {31'b0, bus3.mem_ready}, {31'b0, c % 5 == 4});
        end
        @(negedge clk);
        bus0.mem_rd = 1'b0; bus3.mem_rd = 1'b0;

        // Random phase: seed 16 words, then mixed traffic against the model.
        for (int w = 0; w < 16; w++) begin
            dir = 32'(w) << 2;
            out = $urandom;
            model_op(1'b0, 1'b1, dir, out, 4'hF, eout, eerr);
            do_op(1'b0, 1'b1, dir, out, 4'hF, out, err, lat, t_acc);
        end
        for (int k = 0; k < 60; k++) begin
            logic [31:0] dato;
            logic [3:0]  be;
            int          sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      dir = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 1) dir = 32'(256 + $urandom_range(0, 100)) << 2;
            else               dir = 32'($urandom_range(0, 15)) << 2;
            sel = int'($urandom_range(0, 9));
            rd = (sel == 0) || (sel > 4);
            wd = (sel >= 0) && (sel <= 4);
            dato = $urandom;
            be = 4'($urandom);
            model_op(rd, wd, dir, dato, be, eout, eerr);
            do_op(rd, wd, dir, dato, be, out, err, lat, t_acc);
            check($sformatf("rand%0d out", k), out, eout);
            check($sformatf("rand%0d err", k), {31'b0, err}, {31'b0, eerr});
            check($sformatf("rand%0d latency", k), lat, 2);
        end

`ifdef DMEM_CNT_EN
        @(posedge clk); #1;
        check("rd_count", rd_count, 32'(exp_rd_cnt));
        check("wr_count", wr_count, 32'(exp_wr_cnt));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
